// File: rtl/vjtag_reg_ctrl.sv
// vjtag_reg_ctrl: sequences virtual JTAG DR scans and turns completed scans
// into single-beat register-bus transactions (address load, write, read).
// Optional feature macro: VJTAG_AUTOINC_EN -- when defined, reg_addr advances
// by one after every acknowledged write or read.
module vjtag_reg_ctrl #(
    parameter int          AW      = 8,
    parameter int          DW      = 32,
    parameter logic [31:0] IDCODE  = 32'h1A5C_0001,
    parameter int          TIMEOUT = 255
) (
    input  logic          tck,
    input  logic          rst,
    input  logic          tdi,
    output logic          tdo,
    input  logic [3:0]    ir_in,
    output logic [3:0]    ir_out,
    input  logic          virtual_state_cdr,
    input  logic          virtual_state_sdr,
    input  logic          virtual_state_e1dr,
    input  logic          virtual_state_pdr,
    input  logic          virtual_state_e2dr,
    input  logic          virtual_state_udr,
    input  logic          virtual_state_cir,
    input  logic          virtual_state_uir,
    output logic [AW-1:0] reg_addr,
    output logic [DW-1:0] reg_wdata,
    output logic          reg_wr,
    output logic          reg_rd,
    input  logic [DW-1:0] reg_rdata,
    input  logic          reg_ack
);

    localparam logic [3:0]  IR_IDCODE = 4'h1;
    localparam logic [3:0]  IR_ADDR   = 4'h2;
    localparam logic [3:0]  IR_WRITE  = 4'h3;
    localparam logic [3:0]  IR_READ   = 4'h4;
    localparam logic [3:0]  IR_STATUS = 4'h5;

    localparam logic [5:0]  LEN_AW    = 6'(AW);
    localparam logic [5:0]  LEN_DW    = 6'(DW);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_WR = 2'd1,
        ST_WAIT_RD = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] tmo_cnt;
    logic [15:0] tmo_next;

    logic [31:0] shift_reg;
    logic [31:0] shift_next;
    logic [31:0] capture_val;
    logic [5:0]  bit_cnt;
    logic [5:0]  dr_len;
    logic [4:0]  dr_msb;
    logic        clear_pending;

    logic [DW-1:0] rd_hold;
    logic          timeout_err;
    logic          short_err;
    logic          late_err;
    logic          busy;

    logic dr_hold;
    logic shift_en;
    logic scan_short;
    logic bus_scan;
    logic req_wr;
    logic req_rd;
    logic addr_load;
    logic start_wr;
    logic start_rd;
    logic late_req;
    logic bus_done;
    logic bus_abort;

    assign busy   = (state != ST_IDLE);
    assign ir_out = {timeout_err, short_err, late_err, busy};

    // Select the DR length and capture value for the current instruction
    always_comb begin
        dr_len      = 6'd1;
        capture_val = 32'd0;
        case (ir_in)
            IR_IDCODE: begin
                dr_len      = 6'd32;
                capture_val = IDCODE;
            end
            IR_ADDR: begin
                dr_len      = LEN_AW;
                capture_val = 32'(reg_addr);
            end
            IR_WRITE: begin
                dr_len      = LEN_DW;
                capture_val = 32'd0;
            end
            IR_READ: begin
                dr_len      = LEN_DW;
                capture_val = 32'(rd_hold);
            end
            IR_STATUS: begin
                dr_len      = 6'd4;
                capture_val = {28'd0, ir_out};
            end
            default: begin
                dr_len      = 6'd1;
                capture_val = 32'd0;
            end
        endcase
    end

    // Right shift with tdi entering at the top bit of the selected DR length
    always_comb begin
        dr_msb                = 5'(dr_len - 6'd1);
        shift_next            = {1'b0, shift_reg[31:1]};
        shift_next[dr_msb]    = tdi;
        dr_hold               = virtual_state_e1dr | virtual_state_pdr | virtual_state_e2dr;
        shift_en              = virtual_state_sdr & ~dr_hold;
        scan_short            = (bit_cnt < dr_len);
        bus_scan              = (ir_in == IR_ADDR) || (ir_in == IR_WRITE) || (ir_in == IR_READ);
        req_wr                = virtual_state_udr && (ir_in == IR_WRITE) && !scan_short;
        req_rd                = (virtual_state_udr && (ir_in == IR_READ) && !scan_short) ||
                                (virtual_state_uir && (ir_in == IR_READ));
        addr_load             = virtual_state_udr && (ir_in == IR_ADDR) && !scan_short && !busy;
        late_req              = busy && (req_wr || req_rd ||
                                (virtual_state_udr && (ir_in == IR_ADDR) && !scan_short));
    end

    // Bus FSM next-state: launch requests from IDLE, wait for ack or timeout
    always_comb begin
        next_state = state;
        tmo_next   = tmo_cnt;
        start_wr   = 1'b0;
        start_rd   = 1'b0;
        bus_done   = 1'b0;
        bus_abort  = 1'b0;
        case (state)
            ST_IDLE: begin
                tmo_next = 16'd0;
                if (req_wr) begin
                    start_wr   = 1'b1;
                    next_state = ST_WAIT_WR;
                end else if (req_rd) begin
                    start_rd   = 1'b1;
                    next_state = ST_WAIT_RD;
                end
            end
            ST_WAIT_WR, ST_WAIT_RD: begin
                if (reg_ack) begin
                    bus_done   = 1'b1;
                    next_state = ST_IDLE;
                end else if (tmo_cnt == TMO_LAST) begin
                    bus_abort  = 1'b1;
                    next_state = ST_IDLE;
                end else begin
                    tmo_next = tmo_cnt + 16'd1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // FSM state and timeout counter registers
    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            tmo_cnt <= 16'd0;
        end else begin
            state   <= next_state;
            tmo_cnt <= tmo_next;
        end
    end

    // DR capture/shift datapath, bit counter and STATUS clear request
    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            shift_reg     <= 32'd0;
            bit_cnt       <= 6'd0;
            tdo           <= 1'b0;
            clear_pending <= 1'b0;
        end else if (virtual_state_cir) begin
            clear_pending <= 1'b0;
        end else if (virtual_state_cdr) begin
            shift_reg     <= capture_val;
            bit_cnt       <= 6'd0;
            clear_pending <= 1'b0;
        end else if (shift_en) begin
            shift_reg <= shift_next;
            tdo       <= shift_reg[0];
            if (bit_cnt != 6'd63) begin
                bit_cnt <= bit_cnt + 6'd1;
            end
            if ((bit_cnt == 6'd0) && (ir_in == IR_STATUS)) begin
                clear_pending <= tdi;
            end
        end
    end

    // Register-bus outputs and read-data holding register
    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
            rd_hold   <= '0;
        end else begin
            if (addr_load) begin
                reg_addr <= shift_reg[AW-1:0];
            end
            if (start_wr) begin
                reg_wdata <= shift_reg[DW-1:0];
                reg_wr    <= 1'b1;
            end
            if (start_rd) begin
                reg_rd <= 1'b1;
            end
            if (bus_done || bus_abort) begin
                reg_wr <= 1'b0;
                reg_rd <= 1'b0;
            end
            if (bus_done && (state == ST_WAIT_RD)) begin
                rd_hold <= reg_rdata;
            end
`ifdef VJTAG_AUTOINC_EN
            if (bus_done) begin
                reg_addr <= reg_addr + AW'(1);
            end
`endif
        end
    end

    // Sticky error flags: cleared by a STATUS update, sets take priority
    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            timeout_err <= 1'b0;
            short_err   <= 1'b0;
            late_err    <= 1'b0;
        end else begin
            if (virtual_state_udr && (ir_in == IR_STATUS) && clear_pending) begin
                timeout_err <= 1'b0;
                short_err   <= 1'b0;
                late_err    <= 1'b0;
            end
            if (virtual_state_udr && bus_scan && scan_short) begin
                short_err <= 1'b1;
            end
            if (late_req) begin
                late_err <= 1'b1;
            end
            if (virtual_state_cdr && (ir_in == IR_READ) && (state == ST_WAIT_RD)) begin
                late_err <= 1'b1;
            end
            if (bus_abort) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vjtag_reg_ctrl.sv
// tb_vjtag_reg_ctrl: directed self-checking bench for vjtag_reg_ctrl using
// hand-computed expected values. Builds with or without VJTAG_AUTOINC_EN.
module tb_vjtag_reg_ctrl;

    localparam logic [7:0] S_NONE = 8'h00;
    localparam logic [7:0] S_CDR  = 8'h80;
    localparam logic [7:0] S_SDR  = 8'h40;
    localparam logic [7:0] S_E1DR = 8'h20;
    localparam logic [7:0] S_PDR  = 8'h10;
    localparam logic [7:0] S_E2DR = 8'h08;
    localparam logic [7:0] S_UDR  = 8'h04;
    localparam logic [7:0] S_CIR  = 8'h02;
    localparam logic [7:0] S_UIR  = 8'h01;

    logic        tck = 1'b0;
    logic        rst;
    logic        tdi;
    logic        tdo;
    logic [3:0]  ir_in;
    logic [3:0]  ir_out;
    logic        v_cdr, v_sdr, v_e1dr, v_pdr, v_e2dr, v_udr, v_cir, v_uir;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_wr;
    logic        reg_rd;
    logic [31:0] reg_rdata;
    logic        reg_ack;

    int checks   = 0;
    int failures = 0;

    logic [31:0] scan_out;
    int          n;

    vjtag_reg_ctrl dut (
        .tck                (tck),
        .rst                (rst),
        .tdi                (tdi),
        .tdo                (tdo),
        .ir_in              (ir_in),
        .ir_out             (ir_out),
        .virtual_state_cdr  (v_cdr),
        .virtual_state_sdr  (v_sdr),
        .virtual_state_e1dr (v_e1dr),
        .virtual_state_pdr  (v_pdr),
        .virtual_state_e2dr (v_e2dr),
        .virtual_state_udr  (v_udr),
        .virtual_state_cir  (v_cir),
        .virtual_state_uir  (v_uir),
        .reg_addr           (reg_addr),
        .reg_wdata          (reg_wdata),
        .reg_wr             (reg_wr),
        .reg_rd             (reg_rd),
        .reg_rdata          (reg_rdata),
        .reg_ack            (reg_ack)
    );

    always #5 tck = ~tck;

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Hold the given TAP strobes for one tck cycle, then release them
    task automatic applyStimulus(input logic [7:0] strobes);
        {v_cdr, v_sdr, v_e1dr, v_pdr, v_e2dr, v_udr, v_cir, v_uir} = strobes;
        @(posedge tck);
        #1;
        {v_cdr, v_sdr, v_e1dr, v_pdr, v_e2dr, v_udr, v_cir, v_uir} = S_NONE;
    endtask

    task automatic loadIr(input logic [3:0] value);
        ir_in = value;
        applyStimulus(S_CIR);
        applyStimulus(S_UIR);
    endtask

    // Full DR scan, LSB first; optional pause after bit pause_at
    task automatic scanDr(input logic [31:0] din, input int nbits, input int pause_at,
                          output logic [31:0] dout);
        dout = 32'd0;
        applyStimulus(S_CDR);
        for (int i = 0; i < nbits; i++) begin
            tdi = din[i];
            applyStimulus(S_SDR);
            dout[i] = tdo;
            if (i == pause_at) begin
                tdi = 1'b1;
                applyStimulus(S_E1DR);
                applyStimulus(S_PDR);
                applyStimulus(S_PDR);
                applyStimulus(S_E2DR);
            end
        end
        tdi = 1'b0;
        applyStimulus(S_E1DR);
        applyStimulus(S_UDR);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        tdi       = 1'b0;
        ir_in     = 4'h0;
        reg_rdata = 32'd0;
        reg_ack   = 1'b0;
        {v_cdr, v_sdr, v_e1dr, v_pdr, v_e2dr, v_udr, v_cir, v_uir} = S_NONE;
        repeat (3) @(posedge tck);
        #1;
        checkOutput("reset_tdo",    32'(tdo),       32'd0);
        checkOutput("reset_ir_out", 32'(ir_out),    32'd0);
        checkOutput("reset_addr",   32'(reg_addr),  32'd0);
        checkOutput("reset_wdata",  reg_wdata,      32'd0);
        checkOutput("reset_wr_rd",  32'({reg_wr, reg_rd}), 32'd0);
        rst = 1'b0;
        applyStimulus(S_NONE);

        // IDCODE readout
        loadIr(4'h1);
        scanDr(32'd0, 32, -1, scan_out);
        checkOutput("idcode", scan_out, 32'h1A5C_0001);
        checkOutput("idcode_ir_out", 32'(ir_out), 32'd0);

        // BYPASS and an unused opcode: one-bit delay with captured 0
        loadIr(4'h0);
        scanDr(32'h5, 3, -1, scan_out);
        checkOutput("bypass", scan_out, 32'h2);
        loadIr(4'hF);
        scanDr(32'h5, 3, -1, scan_out);
        checkOutput("bypass_0xf", scan_out, 32'h2);

        // ADDR load with a pause in the middle of the scan
        loadIr(4'h2);
        scanDr(32'h3C, 8, 3, scan_out);
        checkOutput("addr_capture", scan_out, 32'h0);
        checkOutput("addr_load", 32'(reg_addr), 32'h3C);

        // WRITE, ack three cycles after the request appears
        loadIr(4'h3);
        scanDr(32'hDEAD_BEEF, 32, -1, scan_out);
        checkOutput("wr_req", 32'(reg_wr), 32'd1);
        checkOutput("wr_addr", 32'(reg_addr), 32'h3C);
        checkOutput("wr_data", reg_wdata, 32'hDEAD_BEEF);
        checkOutput("wr_busy", 32'(ir_out), 32'h1);
        applyStimulus(S_NONE);
        applyStimulus(S_NONE);
        checkOutput("wr_held", 32'(reg_wr), 32'd1);
        reg_ack = 1'b1;
        applyStimulus(S_NONE);
        reg_ack = 1'b0;
        checkOutput("wr_dropped", 32'(reg_wr), 32'd0);
        checkOutput("wr_not_busy", 32'(ir_out), 32'd0);
`ifdef VJTAG_AUTOINC_EN
        checkOutput("wr_autoinc", 32'(reg_addr), 32'h3D);
`else
        checkOutput("wr_addr_kept", 32'(reg_addr), 32'h3C);
`endif

        // READ: prefetch on uir, data visible on the next scan
        loadIr(4'h4);
        checkOutput("rd_uir_req", 32'(reg_rd), 32'd1);
        reg_rdata = 32'h1234_5678;
        reg_ack   = 1'b1;
        applyStimulus(S_NONE);
        reg_ack   = 1'b0;
        reg_rdata = 32'hFFFF_FFFF;
        checkOutput("rd_dropped", 32'(reg_rd), 32'd0);
        scanDr(32'd0, 32, -1, scan_out);
        checkOutput("rd_data", scan_out, 32'h1234_5678);
        checkOutput("rd_reissue", 32'(reg_rd), 32'd1);
        reg_rdata = 32'hCAFE_F00D;
        reg_ack   = 1'b1;
        applyStimulus(S_NONE);
        reg_ack   = 1'b0;
        checkOutput("rd_flags_clean", 32'(ir_out), 32'd0);

        // Short WRITE sets short_err; STATUS clears only when first bit is 1
        loadIr(4'h3);
        scanDr(32'h1_1111, 20, -1, scan_out);
        checkOutput("short_no_wr", 32'(reg_wr), 32'd0);
        checkOutput("short_flag", 32'(ir_out), 32'h4);
        loadIr(4'h5);
        scanDr(32'h0, 4, -1, scan_out);
        checkOutput("status_capture", scan_out, 32'h4);
        checkOutput("status_keep", 32'(ir_out), 32'h4);
        scanDr(32'h1, 4, -1, scan_out);
        checkOutput("status_clear", 32'(ir_out), 32'h0);

        // Read timeout: request lasts TIMEOUT cycles, rd_hold unchanged
        loadIr(4'h4);
        n = 0;
        while (reg_rd && n < 400) begin
            applyStimulus(S_NONE);
            n++;
        end
        checkOutput("timeout_cycles", 32'(n), 32'd255);
        checkOutput("timeout_flag", 32'(ir_out), 32'h8);
        scanDr(32'd0, 32, -1, scan_out);
        checkOutput("timeout_rd_hold", scan_out, 32'hCAFE_F00D);

        // READ scan while the prefetch is outstanding: stale data, late_err
        scanDr(32'd0, 32, -1, scan_out);
        checkOutput("late_stale", scan_out, 32'hCAFE_F00D);
        checkOutput("late_flags", 32'(ir_out), 32'hB);
        reg_rdata = 32'h55AA_55AA;
        reg_ack   = 1'b1;
        applyStimulus(S_NONE);
        reg_ack   = 1'b0;
        checkOutput("late_acked", 32'({reg_rd, ir_out}), 32'h0A);
        scanDr(32'd0, 32, -1, scan_out);
        checkOutput("late_rd_data", scan_out, 32'h55AA_55AA);
        reg_ack = 1'b1;
        applyStimulus(S_NONE);
        reg_ack = 1'b0;

        // Asynchronous reset during an outstanding write
        loadIr(4'h3);
        scanDr(32'hA5A5_A5A5, 32, -1, scan_out);
        checkOutput("rst_pre_wr", 32'(reg_wr), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_async_wr", 32'(reg_wr), 32'd0);
        checkOutput("rst_async_out",
                    {reg_addr, 3'd0, tdo, ir_out, 15'd0, reg_rd}, 32'd0);
        checkOutput("rst_async_wdata", reg_wdata, 32'd0);
        @(posedge tck);
        #1;
        rst     = 1'b0;
        reg_ack = 1'b1;
        applyStimulus(S_NONE);
        reg_ack = 1'b0;
        applyStimulus(S_NONE);
        checkOutput("rst_late_ack",
                    {reg_addr, 6'd0, reg_wr, reg_rd, ir_out, 12'd0}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
